// File: rtl/alu_output_ctrl.sv
// Output side of the board ALU: result/carry capture, LED mirror, sequential binary-to-BCD
// conversion and a multiplexed 4-digit 7-segment driver. Define ALU_OUT_HEX_EN for hex digits.
module alu_output_ctrl #(
  parameter int N_DATA      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [N_DATA-1:0] i_result,
  input  logic              i_carry,
  input  logic              i_load,
  output logic [N_DATA-1:0] o_led,
  output logic [6:0]        o_seg,
  output logic              o_dp,
  output logic [3:0]        o_an,
  output logic              o_busy
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t            state_q, state_d;
  logic [N_DATA-1:0] result_q, result_d;
  logic              carry_q, carry_d;
  logic [15:0]       dig_q, dig_d;
  logic [RW-1:0]     ref_q, ref_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
`ifndef ALU_OUT_HEX_EN
  localparam int SW = 16 + N_DATA;
  logic [SW-1:0]     sh_q, sh_d;
  logic [3:0]        bitcnt_q, bitcnt_d;
`endif

  function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
`ifdef ALU_OUT_HEX_EN
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      4'hF: return 7'b0001110;
`endif
      default: return 7'b1111111;
    endcase
  endfunction

  // Leading-zero blanking on the upper three digits; digit 0 is always lit.
  function automatic logic [6:0] digit_seg(input logic [15:0] d, input logic [1:0] idx);
    logic [3:0] n;
    logic       blank;
    case (idx)
      2'd0:    begin n = d[3:0];   blank = 1'b0;             end
      2'd1:    begin n = d[7:4];   blank = (d[15:4] == '0);  end
      2'd2:    begin n = d[11:8];  blank = (d[15:8] == '0);  end
      default: begin n = d[15:12]; blank = (d[15:12] == '0); end
    endcase
    return blank ? 7'b1111111 : seg_encode(n);
  endfunction

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    dig_d    = dig_q;
    ref_d    = ref_q;
    idx_d    = idx_q;
`ifdef ALU_OUT_HEX_EN
    // DONE copies the already-captured value, so a load during DONE is still taken.
    case (state_q)
      DONE: begin
        dig_d   = 16'(result_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (i_load) begin
      result_d = i_result;
      carry_d  = i_carry;
      state_d  = DONE;
    end
`else
    sh_d     = sh_q;
    bitcnt_d = bitcnt_q;
    case (state_q)
      IDLE: begin
        if (i_load) begin
          result_d = i_result;
          carry_d  = i_carry;
          sh_d     = {16'd0, i_result};
          bitcnt_d = '0;
          state_d  = CONV;
        end
      end
      CONV: begin
        sh_d     = {dabble_adjust(sh_q[SW-1 -: 16]), sh_q[N_DATA-1:0]} << 1;
        bitcnt_d = bitcnt_q + 4'd1;
        if (bitcnt_q == 4'(N_DATA - 1)) state_d = DONE;
      end
      DONE: begin
        dig_d   = sh_q[SW-1 -: 16];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`endif
    if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      ref_d = ref_q + 1'b1;
    end
    // Outputs derive from next-state values so anode, segments and dp change together.
    an_d  = ~(4'b0001 << idx_d);
    seg_d = digit_seg(dig_d, idx_d);
    dp_d  = ~((idx_d == 2'd3) && carry_d);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      dig_q    <= '0;
      ref_q    <= '0;
      idx_q    <= '0;
      an_q     <= 4'b1110;
      seg_q    <= 7'b1000000;
      dp_q     <= 1'b1;
`ifndef ALU_OUT_HEX_EN
      sh_q     <= '0;
      bitcnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      dig_q    <= dig_d;
      ref_q    <= ref_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
`ifndef ALU_OUT_HEX_EN
      sh_q     <= sh_d;
      bitcnt_q <= bitcnt_d;
`endif
    end
  end

  assign o_led = result_q;
  assign o_an  = an_q;
  assign o_seg = seg_q;
  assign o_dp  = dp_q;
`ifdef ALU_OUT_HEX_EN
  assign o_busy = 1'b0;
`else
  assign o_busy = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_alu_output_ctrl.sv
// Directed bench for alu_output_ctrl (N_DATA=8, REFRESH_DIV=4): reset state, scan timing,
// decimal display vectors, dropped loads, reset mid-conversion, and the hex build.
module tb_alu_output_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst, ld, cy;
  logic [N-1:0] res;
  logic [N-1:0] led;
  logic [6:0]   seg;
  logic         dp, busy;
  logic [3:0]   an;

  int total = 0;
  int bad   = 0;

  alu_output_ctrl #(.N_DATA(N), .REFRESH_DIV(4)) dut (
    .i_clock(clk), .i_reset(rst), .i_result(res), .i_carry(cy), .i_load(ld),
    .o_led(led), .o_seg(seg), .o_dp(dp), .o_an(an), .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] val;
    logic       carry;
    string      disp;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [6:0] char2seg(input byte c);
    case (c)
      "0": return 7'h40;
      "1": return 7'h79;
      "2": return 7'h24;
      "3": return 7'h30;
      "4": return 7'h19;
      "5": return 7'h12;
      "6": return 7'h02;
      "7": return 7'h78;
      "8": return 7'h00;
      "9": return 7'h10;
      "A": return 7'h08;
      "B": return 7'h03;
      default: return 7'h7F;
    endcase
  endfunction

  // Pulse i_load for one edge; afterwards the bench sits just past the capture edge.
  task automatic load(input logic [7:0] v, input logic c);
    res = v;
    cy  = c;
    ld  = 1'b1;
    step();
    ld  = 1'b0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
  endtask

  // Watch 16 cycles (one full scan), checking anode shape and dp, then the segment codes.
  task automatic check_disp(input string nm, input string exp, input logic c);
    logic [6:0] seen [4];
    int         d;
    for (int i = 0; i < 4; i++) seen[i] = 7'h55;
    for (int k = 0; k < 16; k++) begin
      case (an)
        4'b1110: d = 0;
        4'b1101: d = 1;
        4'b1011: d = 2;
        4'b0111: d = 3;
        default: d = -1;
      endcase
      if (d < 0) chk($sformatf("%s an onehot", nm), an, 4'b1110);
      else seen[d] = seg;
      chk($sformatf("%s dp k%0d", nm, k), dp, (an == 4'b0111 && c) ? 0 : 1);
      step();
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s seg digit%0d", nm, i), seen[i], char2seg(exp[3-i]));
  endtask

  initial begin
    int n;
    rst = 1'b0; ld = 1'b0; cy = 1'b0; res = '0;
    vt[0] = '{8'd255, 1'b0, " 255"};
    vt[1] = '{8'd7,   1'b1, "   7"};
    vt[2] = '{8'd0,   1'b0, "   0"};
    vt[3] = '{8'd100, 1'b0, " 100"};
    vt[4] = '{8'd42,  1'b1, "  42"};
    vt[5] = '{8'd10,  1'b0, "  10"};
    vt[6] = '{8'd128, 1'b0, " 128"};
    vt[7] = '{8'd9,   1'b0, "   9"};

    do_reset();
    chk("reset led", led, 0);
    chk("reset an", an, 4'b1110);
    chk("reset seg", seg, 7'b1000000);
    chk("reset dp", dp, 1);
    chk("reset busy", busy, 0);

    // Each anode is held exactly REFRESH_DIV=4 cycles, starting right out of reset.
    for (int k = 0; k < 20; k++) begin
      logic [3:0] ea;
      ea = ~(4'b0001 << ((k / 4) % 4));
      chk($sformatf("scan an k%0d", k), an, ea);
      step();
    end

`ifndef ALU_OUT_HEX_EN
    for (int i = 0; i < 8; i++) begin
      load(vt[i].val, vt[i].carry);
      chk($sformatf("vec%0d led", i), led, vt[i].val);
      chk($sformatf("vec%0d busy start", i), busy, 1);
      busy_len(n);
      chk($sformatf("vec%0d busy cycles", i), n, 9);
      check_disp($sformatf("vec%0d", i), vt[i].disp, vt[i].carry);
    end

    // A second load during conversion is dropped.
    load(8'd100, 1'b0);
    step();
    step();
    load(8'd42, 1'b1);
    chk("drop conv led", led, 100);
    busy_len(n);
    chk("drop conv busy cycles", n, 6);
    check_disp("drop conv", " 100", 1'b0);

    // A load in the DONE cycle is dropped; the following IDLE cycle accepts one.
    load(8'd55, 1'b0);
    for (int k = 0; k < 8; k++) step();
    chk("done state busy", busy, 1);
    load(8'd77, 1'b1);
    chk("done drop busy", busy, 0);
    chk("done drop led", led, 55);
    load(8'd77, 1'b1);
    chk("after done led", led, 77);
    chk("after done busy", busy, 1);
    busy_len(n);
    check_disp("after done", "  77", 1'b1);

    // Reset mid-conversion aborts without a partial digit update.
    load(8'd200, 1'b1);
    step();
    step();
    step();
    do_reset();
    chk("abort busy", busy, 0);
    chk("abort led", led, 0);
    check_disp("abort", "   0", 1'b0);
    load(8'd9, 1'b0);
    busy_len(n);
    chk("post abort busy cycles", n, 9);
    check_disp("post abort", "   9", 1'b0);
`else
    load(8'hAB, 1'b0);
    chk("hex busy", busy, 0);
    chk("hex led", led, 8'hAB);
    step();
    check_disp("hex AB", "  AB", 1'b0);
    load(8'h12, 1'b1);
    load(8'h34, 1'b1);
    chk("hex b2b busy", busy, 0);
    chk("hex b2b led", led, 8'h34);
    step();
    check_disp("hex 34", "  34", 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
